// File: rtl/ram_responder.sv
// CPU data-port responder: synchronous read-first RAM plus a 3-word I/O window (TX byte FIFO, RX holding register).
// Reads return 1 cycle after the edge; pushes to a full FIFO are dropped and set sticky ovf; RX stalls via o_in_ready.
module ram_responder #(
  parameter int g_RAM_WIDTH  = 9,
  parameter int g_RAM_ADDR   = 11,
  parameter int g_FIFO_DEPTH = 8,
  parameter int g_IO_BASE    = 2040
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ram_en,
  input  logic                   i_ram_we,
  input  logic                   i_ram_re,
  input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  output logic [7:0]             o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  input  logic [7:0]             i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready
);

  localparam int c_pw = $clog2(g_FIFO_DEPTH);
  localparam logic [g_RAM_ADDR-1:0] c_addr_out    = g_RAM_ADDR'(g_IO_BASE);
  localparam logic [g_RAM_ADDR-1:0] c_addr_status = g_RAM_ADDR'(g_IO_BASE + 1);
  localparam logic [g_RAM_ADDR-1:0] c_addr_in     = g_RAM_ADDR'(g_IO_BASE + 2);

  logic [g_RAM_WIDTH-1:0] ram [2**g_RAM_ADDR];
  logic [7:0]             fifo_mem [g_FIFO_DEPTH];
  logic [c_pw:0]          wr_ptr;
  logic [c_pw:0]          rd_ptr;
  logic                   ovf;
  logic                   rx_valid;
  logic [7:0]             rx_byte;

  logic                   wr_en;
  logic                   rd_en;
  logic                   is_out;
  logic                   is_status;
  logic                   is_in;
  logic                   is_io;
  logic                   tx_empty;
  logic                   tx_full;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   rx_clr;
  logic                   rx_take;
  logic [g_RAM_WIDTH-1:0] io_rdata;

  assign wr_en     = i_ram_en && i_ram_we;
  assign rd_en     = i_ram_en && i_ram_re && !i_ram_we;
  assign is_out    = (i_ram_addr == c_addr_out);
  assign is_status = (i_ram_addr == c_addr_status);
  assign is_in     = (i_ram_addr == c_addr_in);
  assign is_io     = is_out || is_status || is_in;

  // Equal low bits with differing wrap bits means the writer is a full lap ahead.
  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_full  = (wr_ptr[c_pw] != rd_ptr[c_pw]) &&
                    (wr_ptr[c_pw-1:0] == rd_ptr[c_pw-1:0]);
  assign push_req = wr_en && is_out;
  assign push     = push_req && !tx_full;
  assign pop      = !tx_empty && i_out_ready;

  assign rx_clr  = wr_en && is_in;
  assign rx_take = i_in_valid && !rx_valid;

  assign o_out_valid = !tx_empty;
  assign o_out_data  = fifo_mem[rd_ptr[c_pw-1:0]];
  assign o_in_ready  = !rx_valid;

  always_comb begin
    io_rdata = '0;
    if (is_status) begin
      io_rdata = g_RAM_WIDTH'({rx_valid, ovf, tx_empty, tx_full});
    end else if (is_in) begin
      io_rdata = g_RAM_WIDTH'(rx_byte);
    end
  end

  // Array storage is never reset; a write coinciding with reset is discarded.
  always_ff @(posedge i_clk) begin
    if (wr_en && !is_io && !i_rst) begin
      ram[i_ram_addr] <= i_ram_data;
    end
    if (push && !i_rst) begin
      fifo_mem[wr_ptr[c_pw-1:0]] <= i_ram_data[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ram_data <= '0;
    end else if (rd_en) begin
      o_ram_data <= is_io ? io_rdata : ram[i_ram_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (c_pw + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (c_pw + 1)'(1);
      end
      if (push_req && tx_full) begin
        ovf <= 1'b1;
      end else if (wr_en && is_status && i_ram_data[2]) begin
        ovf <= 1'b0;
      end
    end
  end

  // A clear only matters while a byte is held, and then ready is low, so capture never races it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else if (rx_take) begin
      rx_valid <= 1'b1;
      rx_byte  <= i_in_data;
    end else if (rx_clr) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
